// File: rtl/upc_scan_latch.sv
// upc_scan_latch: debounced scan key capturing the UPC code and mark bit, with a scan pulse and a wrapping scan count.
module upc_scan_latch #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_W = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               key_n_i,
    input  logic [2:0]         upc_in_i,
    input  logic               mark_in_i,
    input  logic               clear_i,
    output logic [2:0]         upc_q_o,
    output logic               mark_q_o,
    output logic               scan_pulse_o,
    output logic [COUNT_W-1:0] scan_count_o,
    output logic               busy_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               s1_q, s2_q, key_s;
    logic [2:0]         upc_q, upc_d;
    logic               mark_q, mark_d;
    logic               pulse_q, pulse_d;
    logic [COUNT_W-1:0] count_q, count_d;

    assign key_s = ~s2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        upc_d   = upc_q;
        mark_d  = mark_q;
        pulse_d = 1'b0;
        count_d = count_q;
        case (state_q)
            IDLE: if (key_s) begin
                state_d = PRESS_DB;
                cnt_d   = '0;
            end
            PRESS_DB: if (!key_s) state_d = IDLE;
            else if (cnt_q == LAST) begin
                state_d = HELD;
                upc_d   = upc_in_i;
                mark_d  = mark_in_i;
                pulse_d = 1'b1;
                count_d = count_q + 1'b1;
            end else cnt_d = cnt_q + 1'b1;
            HELD: if (!key_s) begin
                state_d = REL_DB;
                cnt_d   = '0;
            end
            REL_DB: if (key_s) state_d = HELD;
            else if (cnt_q == LAST) state_d = IDLE;
            else cnt_d = cnt_q + 1'b1;
            default: state_d = IDLE;
        endcase
        // clear wins over a same-edge capture for the count only
        if (clear_i) count_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            upc_q   <= '0;
            mark_q  <= 1'b0;
            pulse_q <= 1'b0;
            count_q <= '0;
        end else begin
            s1_q    <= key_n_i;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            upc_q   <= upc_d;
            mark_q  <= mark_d;
            pulse_q <= pulse_d;
            count_q <= count_d;
        end
    end

    assign upc_q_o      = upc_q;
    assign mark_q_o     = mark_q;
    assign scan_pulse_o = pulse_q;
    assign scan_count_o = count_q;
    assign busy_o       = state_q != IDLE;
endmodule

// File: tb/tb_upc_scan_latch.sv
// tb_upc_scan_latch: run-length reference model of the scan key checked every cycle, plus directed literal checks.
module tb_upc_scan_latch;
    localparam int D = 4;
    localparam int CW = 4;

    logic          clk = 1'b0, reset = 1'b1, key_n = 1'b1, mark_in = 1'b0, clear = 1'b0;
    logic [2:0]    upc_in = 3'd0;
    logic [2:0]    upc_q;
    logic          mark_q, scan_pulse, busy;
    logic [CW-1:0] scan_count;

    int checks = 0, errors = 0, pulses = 0;

    always #5 clk = ~clk;

    upc_scan_latch #(.DEBOUNCE_CYCLES(D), .COUNT_W(CW)) dut (
        .clk_i(clk), .reset_i(reset), .key_n_i(key_n), .upc_in_i(upc_in),
        .mark_in_i(mark_in), .clear_i(clear), .upc_q_o(upc_q), .mark_q_o(mark_q),
        .scan_pulse_o(scan_pulse), .scan_count_o(scan_count), .busy_o(busy)
    );

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a press is accepted once the synchronized key has read pressed for D+1
    // consecutive samples while released; it is released after D+1 consecutive released samples.
    bit            m_valid = 0, m_held, m_last, m_d1, m_d2, m_ks, m_pulse, m_mark;
    int            m_run;
    logic [2:0]    m_upc;
    logic [CW-1:0] m_cnt;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1; m_held = 0; m_last = 0; m_run = 0; m_d1 = 1; m_d2 = 1;
            m_pulse = 0; m_mark = 0; m_upc = 0; m_cnt = 0;
        end else begin
            m_ks = ~m_d2;
            m_d2 = m_d1;
            m_d1 = key_n;
            m_run = (m_ks == m_last) ? m_run + 1 : 1;
            m_last = m_ks;
            m_pulse = 0;
            if (!m_held && m_ks && m_run == D + 1) begin
                m_held = 1; m_pulse = 1; m_upc = upc_in; m_mark = mark_in; m_cnt = m_cnt + 1'b1;
            end else if (m_held && !m_ks && m_run == D + 1) m_held = 0;
            if (clear) m_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("upc_q", upc_q, m_upc);
            chk("mark_q", mark_q, m_mark);
            chk("scan_pulse", scan_pulse, m_pulse);
            chk("scan_count", scan_count, m_cnt);
            chk("busy", busy, m_held || m_last);
            if (scan_pulse) pulses++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(int lo, int hi);
        key_n = 1'b0;
        repeat (lo) tick();
        key_n = 1'b1;
        repeat (hi) tick();
    endtask

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        chk("idle_count", scan_count, 0);
        chk("idle_busy", busy, 0);
        chk("idle_pulses", pulses, 0);
        chk("idle_upc", upc_q, 0);

        upc_in = 3'b101; mark_in = 1'b1;
        press(15, 10);
        @(negedge clk);
        chk("press_upc", upc_q, 5);
        chk("press_mark", mark_q, 1);
        chk("press_count", scan_count, 1);
        chk("press_pulses", pulses, 1);
        chk("press_busy", busy, 0);

        upc_in = 3'b010;
        press(3, 10);
        @(negedge clk);
        chk("short_pulses", pulses, 1);
        chk("short_count", scan_count, 1);
        chk("short_upc", upc_q, 5);

        key_n = 1'b0; repeat (10) tick();
        key_n = 1'b1; repeat (2) tick();
        press(10, 10);
        @(negedge clk);
        chk("glitch_pulses", pulses, 2);
        chk("glitch_count", scan_count, 2);

        reset = 1'b1; repeat (2) tick(); reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            upc_in = 3'($urandom_range(0, 7));
            press(8, 8);
        end
        @(negedge clk);
        chk("wrap_count", scan_count, 0);
        chk("wrap_pulses", pulses, 16);
        press(8, 8);
        upc_in = 3'b011; mark_in = 1'b0;
        key_n = 1'b0;
        repeat (6) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        chk("clr_pulse", scan_pulse, 1);
        chk("clr_count", scan_count, 0);
        chk("clr_upc", upc_q, 3);
        key_n = 1'b1; repeat (10) tick();

        key_n = 1'b0;
        repeat (5) tick();
        reset = 1'b1; key_n = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_count", scan_count, 0);
        chk("rst_upc", upc_q, 0);
        chk("rst_pulse", scan_pulse, 0);
        press(10, 10);
        @(negedge clk);
        chk("rst_after_count", scan_count, 1);

        for (int n = 0; n < 3000; ) begin
            int len;
            key_n = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                clear = ($urandom_range(0, 49) == 0);
                reset = ($urandom_range(0, 399) == 0);
                if ($urandom_range(0, 9) == 0) begin
                    upc_in = 3'($urandom_range(0, 7));
                    mark_in = 1'($urandom_range(0, 1));
                end
                tick();
                n++;
            end
        end
        clear = 1'b0; reset = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
